// File: rtl/dcache_flush_ctrl.sv
// Flush-port sequencer for the data-cache memblock: line write-back (3 cycles/word min, stalls on wb_ready)
// and line fill (1 word/cycle, paced by fill_valid); flush_mode is held high while the port is owned.
module dcache_flush_ctrl #(
  parameter int DATABITS = 32,
  parameter int ADDRBITS = 5,
  parameter int LINEBITS = 2,
  parameter int BANKNUM  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_flush,
  input  logic                start_fill,
  input  logic [LINEBITS-1:0] line_idx,
  output logic                busy,
  output logic                done,
  output logic                flush_mode,
  output logic [ADDRBITS-1:0] flush_addr,
  output logic [DATABITS-1:0] flush_in,
  output logic                flush_we,
  output logic [BANKNUM-1:0]  flush_byteenable,
  input  logic [DATABITS-1:0] mem_rdata,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [ADDRBITS-1:0] wb_addr,
  output logic [DATABITS-1:0] wb_data,
  output logic                wb_last,
  input  logic                fill_valid,
  input  logic [DATABITS-1:0] fill_data,
  output logic                fill_ready
);
  localparam int WORDBITS = ADDRBITS - LINEBITS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB_RD,
    S_WB_CAP,
    S_WB_SEND,
    S_FILL,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WORDBITS-1:0] r_word_cnt;
  logic [WORDBITS-1:0] w_word_cnt_nxt;
  logic [LINEBITS-1:0] r_line;
  logic [LINEBITS-1:0] w_line_nxt;
  logic [DATABITS-1:0] r_wb_data;
  logic [ADDRBITS-1:0] r_wb_addr;
  logic                w_last_word;
  logic                w_cap;
  logic [ADDRBITS-1:0] w_line_addr;

  assign w_last_word = &r_word_cnt;
  assign w_line_addr = {r_line, r_word_cnt};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_word_cnt <= '0;
      r_line     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_word_cnt <= w_word_cnt_nxt;
      r_line     <= w_line_nxt;
    end
  end

  // Memblock read data is valid one cycle after the address, so capture happens in WB_CAP.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb_data <= '0;
      r_wb_addr <= '0;
    end else if (w_cap) begin
      r_wb_data <= mem_rdata;
      r_wb_addr <= w_line_addr;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_word_cnt_nxt = r_word_cnt;
    w_line_nxt     = r_line;
    w_cap          = 1'b0;
    done           = 1'b0;
    flush_mode     = 1'b0;
    flush_addr     = '0;
    flush_in       = '0;
    flush_we       = 1'b0;
    wb_valid       = 1'b0;
    wb_last        = 1'b0;
    fill_ready     = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_word_cnt_nxt = '0;
        // Flush has priority; a simultaneous fill request is dropped.
        if (start_flush) begin
          w_state_nxt = S_WB_RD;
          w_line_nxt  = line_idx;
        end else if (start_fill) begin
          w_state_nxt = S_FILL;
          w_line_nxt  = line_idx;
        end
      end
      S_WB_RD: begin
        flush_mode  = 1'b1;
        flush_addr  = w_line_addr;
        w_state_nxt = S_WB_CAP;
      end
      S_WB_CAP: begin
        flush_mode  = 1'b1;
        flush_addr  = w_line_addr;
        w_cap       = 1'b1;
        w_state_nxt = S_WB_SEND;
      end
      S_WB_SEND: begin
        flush_mode = 1'b1;
        flush_addr = w_line_addr;
        wb_valid   = 1'b1;
        wb_last    = w_last_word;
        if (wb_ready) begin
          w_word_cnt_nxt = r_word_cnt + 1'b1;
          w_state_nxt    = w_last_word ? S_DONE : S_WB_RD;
        end
      end
      S_FILL: begin
        flush_mode = 1'b1;
        flush_addr = w_line_addr;
        flush_in   = fill_data;
        flush_we   = fill_valid;
        fill_ready = 1'b1;
        if (fill_valid) begin
          w_word_cnt_nxt = r_word_cnt + 1'b1;
          if (w_last_word) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        done           = 1'b1;
        w_word_cnt_nxt = '0;
        w_state_nxt    = S_IDLE;
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_word_cnt_nxt = '0;
      end
    endcase
  end

  assign busy             = (r_state != S_IDLE);
  assign flush_byteenable = {BANKNUM{flush_we}};
  assign wb_addr          = r_wb_addr;
  assign wb_data          = r_wb_data;

endmodule

// File: tb/tb_dcache_flush_ctrl.sv
// Bench for dcache_flush_ctrl: memblock environment, line-level reference model checked every cycle.
module tb_dcache_flush_ctrl;
  localparam int DB  = 32;
  localparam int AB  = 5;
  localparam int LB  = 2;
  localparam int BN  = 4;
  localparam int WPL = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_flush, start_fill;
  logic [LB-1:0] line_idx;
  logic          busy, done, flush_mode, flush_we;
  logic [AB-1:0] flush_addr, wb_addr;
  logic [DB-1:0] flush_in, mem_rdata, wb_data, fill_data;
  logic [BN-1:0] flush_byteenable;
  logic          wb_valid, wb_ready, wb_last, fill_valid, fill_ready;

  logic          cpu_we, cpu_rd;
  logic [AB-1:0] cpu_addr;
  logic [DB-1:0] cpu_wdata;
  logic [DB-1:0] env_mem [0:31];

  int n_err = 0;
  int n_checks = 0;
  int tst = 0;
  bit chk_en = 0;
  bit tmo_evt = 0;
  bit fin = 0;

  always #5 clk = ~clk;

  dcache_flush_ctrl #(.DATABITS(DB), .ADDRBITS(AB), .LINEBITS(LB), .BANKNUM(BN)) dut (
    .clk(clk), .reset(reset), .start_flush(start_flush), .start_fill(start_fill),
    .line_idx(line_idx), .busy(busy), .done(done), .flush_mode(flush_mode),
    .flush_addr(flush_addr), .flush_in(flush_in), .flush_we(flush_we),
    .flush_byteenable(flush_byteenable), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
    .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data), .wb_last(wb_last),
    .fill_valid(fill_valid), .fill_data(fill_data), .fill_ready(fill_ready)
  );

  // Memblock stand-in: flush port muxes out the CPU port while flush_mode is high.
  always @(posedge clk) begin
    if (flush_mode) begin
      if (flush_we) env_mem[flush_addr] <= flush_in;
      mem_rdata <= env_mem[flush_addr];
    end else begin
      if (cpu_we) env_mem[cpu_addr] <= cpu_wdata;
      mem_rdata <= env_mem[cpu_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: operation kind, target line, word index, and the phase inside a write-back word.
  int m_op = 0;  // 0 idle, 1 write-back, 2 fill, 3 done
  int m_line = 0, m_word = 0, m_phase = 0, m_starts = 0;
  logic [DB-1:0] ref_mem [0:31];
  int got_n = 0, we_n = 0, dut_done_n = 0;
  logic [31:0] got_a0, got_dlast, we_a0;
  bit rb_pend = 0, fin_chk = 0;
  int rb_addr = 0;

  always @(negedge clk) begin
    bit e_mode, e_we, e_wbv;
    int e_addr;
    if (chk_en) begin
      e_mode = (m_op == 1) || (m_op == 2);
      e_addr = e_mode ? m_line * WPL + m_word : 0;
      e_we   = (m_op == 2) && fill_valid;
      e_wbv  = (m_op == 1) && (m_phase == 2);

      chk("busy", 32'(busy), 32'(m_op != 0));
      chk("done", 32'(done), 32'(m_op == 3));
      chk("flush_mode", 32'(flush_mode), 32'(e_mode));
      chk("flush_addr", 32'(flush_addr), 32'(e_addr));
      chk("flush_we", 32'(flush_we), 32'(e_we));
      chk("byteenable", 32'(flush_byteenable), 32'(e_we ? 4'hF : 4'h0));
      chk("wb_valid", 32'(wb_valid), 32'(e_wbv));
      chk("wb_last", 32'(wb_last), 32'(e_wbv && m_word == WPL - 1));
      chk("fill_ready", 32'(fill_ready), 32'(m_op == 2));
      if (e_we) chk("flush_in", flush_in, fill_data);
      if (e_wbv) begin
        chk("wb_addr", 32'(wb_addr), 32'(e_addr));
        chk("wb_data", wb_data, ref_mem[e_addr]);
      end
      if (tmo_evt) begin
        n_checks++;
        n_err++;
        $display("FAIL timeout: done=0 within cycle budget, required done=1");
      end

      if (wb_valid && wb_ready) begin
        if (got_n == 0) got_a0 = 32'(wb_addr);
        got_dlast = wb_data;
        got_n++;
      end
      if (flush_we) begin
        if (we_n == 0) we_a0 = 32'(flush_addr);
        we_n++;
      end
      if (done) dut_done_n++;

      if (rb_pend) begin
        chk("readback", mem_rdata, ref_mem[rb_addr]);
        if (tst == 2) chk("t2_readback_lit", mem_rdata, 32'h11111110);
      end
      rb_pend = cpu_rd;
      rb_addr = int'(cpu_addr);

      if (reset && tst == 0) begin
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_wb_addr", 32'(wb_addr), 32'h0);
      end
      if (reset && tst == 5 && m_op == 2) chk("t5_writes_before_reset", 32'(we_n), 32'd3);
      if (m_op == 3 && !reset) begin
        case (tst)
          1: begin
            chk("t1_words", 32'(got_n), 32'd8);
            chk("t1_first_addr", got_a0, 32'd8);
            chk("t1_last_data", got_dlast, 32'hA000000F);
            chk("t1_no_we", 32'(we_n), 32'd0);
          end
          2: begin
            chk("t2_writes", 32'(we_n), 32'd8);
            chk("t2_first_waddr", we_a0, 32'd16);
          end
          3: chk("t3_words", 32'(got_n), 32'd8);
          4: begin
            chk("t4_first_addr", got_a0, 32'd24);
            chk("t4_words", 32'(got_n), 32'd8);
            chk("t4_no_we", 32'(we_n), 32'd0);
          end
          5: begin
            chk("t5_restart_writes", 32'(we_n), 32'd8);
            chk("t5_restart_addr", we_a0, 32'd16);
          end
          default: ;
        endcase
      end
      if (fin && !fin_chk) begin
        chk("done_per_start", 32'(dut_done_n), 32'(m_starts));
        fin_chk = 1;
      end

      // Advance the model with the inputs the DUT samples at the coming rising edge.
      if (reset) begin
        if (e_we) ref_mem[e_addr] = fill_data;
        if (m_op == 1 || m_op == 2) m_starts--;
        m_op = 0; m_line = 0; m_word = 0; m_phase = 0;
      end else begin
        case (m_op)
          0: begin
            if (start_flush || start_fill) begin
              m_op = start_flush ? 1 : 2;
              m_line = int'(line_idx);
              m_word = 0;
              m_phase = 0;
              m_starts++;
              got_n = 0;
              we_n = 0;
            end
          end
          1: begin
            if (m_phase < 2) m_phase++;
            else if (wb_ready) begin
              if (m_word == WPL - 1) m_op = 3;
              else begin m_word++; m_phase = 0; end
            end
          end
          2: begin
            if (fill_valid) begin
              ref_mem[m_line * WPL + m_word] = fill_data;
              if (m_word == WPL - 1) m_op = 3;
              else m_word++;
            end
          end
          default: begin m_op = 0; m_word = 0; end
        endcase
      end
      if (cpu_we && !e_mode) ref_mem[cpu_addr] = cpu_wdata;
    end
  end

  // kind: 0 flush, 1 fill, 2 both starts. rmode: 0 ready always, 1 one-in-three, 2 random.
  // fmode: 0 valid always with data fbase+n, 1 random valid and data.
  task automatic run_op(input int kind, input int line, input int rmode, input int fmode,
                        input logic [31:0] fbase, input bit hold, input bit noise);
    int n, cyc;
    bit seen_done, acc;
    n = 0; cyc = 0; seen_done = 0;
    line_idx = LB'(line);
    start_flush = (kind != 1);
    start_fill  = (kind != 0);
    @(posedge clk); #1;
    start_fill = 0;
    while (!seen_done && cyc < 400) begin
      start_flush = hold ? 1'b1 : (noise && $urandom_range(0, 7) == 0);
      if (noise) start_fill = ($urandom_range(0, 7) == 0);
      line_idx = LB'($urandom_range(0, 3));
      case (rmode)
        0: wb_ready = 1'b1;
        1: wb_ready = ($urandom_range(0, 2) == 0);
        default: wb_ready = ($urandom_range(0, 1) == 1);
      endcase
      if (fmode == 0) begin
        fill_valid = 1'b1;
        fill_data = fbase + 32'(n);
      end else begin
        fill_valid = ($urandom_range(0, 9) < 6);
        fill_data = $urandom;
      end
      @(negedge clk);
      acc = fill_valid && fill_ready;
      seen_done = done;
      @(posedge clk); #1;
      if (acc) n++;
      cyc++;
    end
    start_flush = 0; start_fill = 0; fill_valid = 0; wb_ready = 0;
    if (!seen_done) begin
      tmo_evt = 1; reset = 1;
      @(posedge clk); #1;
      tmo_evt = 0; reset = 0;
    end
  endtask

  task automatic cpu_read(input int a);
    cpu_rd = 1; cpu_addr = AB'(a);
    @(posedge clk); #1;
    cpu_rd = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1; start_flush = 0; start_fill = 0; line_idx = '0;
    wb_ready = 0; fill_valid = 0; fill_data = '0;
    cpu_we = 0; cpu_rd = 0; cpu_addr = '0; cpu_wdata = '0;
    repeat (2) @(posedge clk);
    #1 chk_en = 1;
    @(posedge clk); #1;
    reset = 0;
    for (int a = 0; a < 32; a++) begin
      cpu_we = 1; cpu_addr = AB'(a); cpu_wdata = 32'hA0000000 + 32'(a);
      @(posedge clk); #1;
    end
    cpu_we = 0;
    @(posedge clk); #1;

    tst = 1; run_op(0, 1, 0, 0, 32'h0, 0, 0);
    repeat (2) @(posedge clk); #1;
    tst = 2; run_op(1, 2, 0, 0, 32'h11111110, 0, 0);
    @(posedge clk); #1;
    cpu_read(16);
    tst = 3; run_op(0, 0, 1, 0, 32'h0, 0, 0);
    @(posedge clk); #1;
    tst = 4; run_op(2, 3, 2, 0, 32'h0, 0, 0);
    repeat (10) @(posedge clk); #1;

    tst = 5;
    line_idx = 2'd2; start_fill = 1;
    @(posedge clk); #1;
    start_fill = 0; fill_valid = 1; fill_data = 32'h77770000;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      fill_data = 32'h77770001 + 32'(k);
    end
    reset = 1; fill_valid = 0;
    @(posedge clk); #1;
    reset = 0;
    repeat (3) @(posedge clk); #1;
    run_op(1, 2, 0, 0, 32'h55550000, 0, 0);
    @(posedge clk); #1;

    tst = 6; run_op(0, 1, 2, 0, 32'h0, 1, 0);
    repeat (3) @(posedge clk); #1;

    tst = 7;
    for (int i = 0; i < 40; i++) begin
      run_op(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 2, 1, 32'h0, 0, 1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    tst = 8;
    for (int i = 0; i < 8; i++) cpu_read(int'($urandom_range(0, 31)));
    for (int l = 0; l < 4; l++) run_op(0, l, 2, 0, 32'h0, 0, 0);

    fin = 1;
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
